// File: rtl/e_mdu.sv
// e_mdu: multi-cycle multiply/divide unit for the EX stage.
// MULT/MULTU/DIV/DIVU compute into a shadow register at issue. The result is
// copied to HI/LO after a fixed busy countdown. MTHI/MTLO write HI/LO directly.
// Optional feature macro: MDU_MADD_EN enables MADD/MADDU/MSUB (ops 7/8/9).
module e_mdu #(
   parameter int MULT_CYCLES = 5,
   parameter int DIV_CYCLES  = 10
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [3:0]  op,
   input  logic [31:0] A,
   input  logic [31:0] B,
   output logic        busy,
   output logic [31:0] HI,
   output logic [31:0] LO
);

   localparam logic [3:0] OP_MULT  = 4'd1;
   localparam logic [3:0] OP_MULTU = 4'd2;
   localparam logic [3:0] OP_DIV   = 4'd3;
   localparam logic [3:0] OP_DIVU  = 4'd4;
   localparam logic [3:0] OP_MTHI  = 4'd5;
   localparam logic [3:0] OP_MTLO  = 4'd6;
`ifdef MDU_MADD_EN
   localparam logic [3:0] OP_MADD  = 4'd7;
   localparam logic [3:0] OP_MADDU = 4'd8;
   localparam logic [3:0] OP_MSUB  = 4'd9;
`endif

   localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
   localparam int CW   = $clog2(MAXC + 1);

   logic [CW-1:0]      cnt;
   logic [63:0]        shadow;
   logic               launch;
   logic [CW-1:0]      cycles;
   logic [63:0]        res;
   logic signed [63:0] prod_s;
   logic [63:0]        prod_u;
   logic [31:0]        quo_s, rem_s, quo_u, rem_u;

   assign prod_s = $signed({{32{A[31]}}, A}) * $signed({{32{B[31]}}, B});
   assign prod_u = {32'd0, A} * {32'd0, B};

   // Divide results. Divide-by-zero and the one signed overflow case are
   // handled explicitly, so the divider never sees them.
   always_comb begin
      quo_s = 32'hFFFF_FFFF;
      rem_s = A;
      quo_u = 32'hFFFF_FFFF;
      rem_u = A;
      if (B != 32'd0) begin
         quo_u = A / B;
         rem_u = A % B;
         if (A == 32'h8000_0000 && B == 32'hFFFF_FFFF) begin
            quo_s = 32'h8000_0000;
            rem_s = 32'd0;
         end else begin
            quo_s = $signed(A) / $signed(B);
            rem_s = $signed(A) % $signed(B);
         end
      end
   end

   // Decode: does this op launch a countdown, how long, and what result.
   always_comb begin
      launch = 1'b0;
      cycles = '0;
      res    = 64'd0;
      case (op)
         OP_MULT:  begin launch = 1'b1; cycles = CW'(MULT_CYCLES); res = prod_s;         end
         OP_MULTU: begin launch = 1'b1; cycles = CW'(MULT_CYCLES); res = prod_u;         end
         OP_DIV:   begin launch = 1'b1; cycles = CW'(DIV_CYCLES);  res = {rem_s, quo_s}; end
         OP_DIVU:  begin launch = 1'b1; cycles = CW'(DIV_CYCLES);  res = {rem_u, quo_u}; end
`ifdef MDU_MADD_EN
         // Accumulate ops use HI/LO as they stand at issue (never busy then).
         OP_MADD:  begin launch = 1'b1; cycles = CW'(MULT_CYCLES); res = {HI, LO} + prod_s; end
         OP_MADDU: begin launch = 1'b1; cycles = CW'(MULT_CYCLES); res = {HI, LO} + prod_u; end
         OP_MSUB:  begin launch = 1'b1; cycles = CW'(MULT_CYCLES); res = {HI, LO} - prod_s; end
`endif
         default: ;
      endcase
   end

   // Issue, countdown and commit. Start while busy is ignored entirely.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         busy   <= 1'b0;
         cnt    <= '0;
         shadow <= 64'd0;
         HI     <= 32'd0;
         LO     <= 32'd0;
      end else if (busy) begin
         cnt <= cnt - 1'b1;
         if (cnt == CW'(1)) begin
            {HI, LO} <= shadow;
            busy     <= 1'b0;
         end
      end else if (start) begin
         if (launch) begin
            shadow <= res;
            cnt    <= cycles;
            busy   <= 1'b1;
         end else if (op == OP_MTHI) begin
            HI <= A;
         end else if (op == OP_MTLO) begin
            LO <= A;
         end
      end
   end

endmodule

// File: tb/tb_e_mdu.sv
// tb_e_mdu: table-driven vectors with a result scoreboard, plus hand-written
// sequences for MTLO, ignored start while busy, accumulate ops and async reset.
module tb_e_mdu;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        start = 1'b0;
   logic [3:0]  op_i = 4'd0;
   logic [31:0] a_i = 32'd0;
   logic [31:0] b_i = 32'd0;
   logic        busy;
   logic [31:0] HI, LO;

   e_mdu dut (
      .clk(clk), .reset(reset), .start(start), .op(op_i),
      .A(a_i), .B(b_i), .busy(busy), .HI(HI), .LO(LO)
   );

   always #5 clk = ~clk;

   typedef struct {
      string       name;
      logic [3:0]  op;
      logic [31:0] a, b, hi, lo;
      int          cyc;
      bit          poke;
   } vec_t;

   vec_t        vecs[10];
   logic [63:0] sb[$];
   int          n_cmp = 0;
   int          n_bad = 0;
   logic [31:0] mhi = 32'd0, mlo = 32'd0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Issue one op, count busy cycles, then compare HI/LO against the scoreboard.
   task automatic run_op(input string name, input logic [3:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] ehi, input logic [31:0] elo,
                         input int cyc, input bit poke);
      int          cnt;
      logic [63:0] exp;
      sb.push_back({ehi, elo});
      @(negedge clk);
      start = 1'b1; op_i = op; a_i = a; b_i = b;
      @(negedge clk);
      start = 1'b0; op_i = 4'd0;
      cnt = 0;
      while (busy && cnt < 100) begin
         if (cnt == 0) chk({name, " hold"}, {HI, LO}, {mhi, mlo});
         if (poke && cnt == 0) begin
            start = 1'b1; op_i = 4'd5; a_i = 32'h1234;
         end
         @(negedge clk);
         start = 1'b0; op_i = 4'd0;
         cnt++;
      end
      chk({name, " busy cycles"}, 64'(cnt), 64'(cyc));
      exp = sb.pop_front();
      chk({name, " HI:LO"}, {HI, LO}, exp);
      mhi = ehi; mlo = elo;
   endtask

   initial begin
      vecs[0] = '{"mult neg",   4'd1, 32'hFFFF_FFFE, 32'd3,         32'hFFFF_FFFF, 32'hFFFF_FFFA, 5,  1'b0};
      vecs[1] = '{"multu max",  4'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 5,  1'b0};
      vecs[2] = '{"div -7/2",   4'd3, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD, 10, 1'b0};
      vecs[3] = '{"divu 5/0",   4'd4, 32'd5,         32'd0,         32'd5,         32'hFFFF_FFFF, 10, 1'b1};
      vecs[4] = '{"div ovf",    4'd3, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         32'h8000_0000, 10, 1'b0};
      vecs[5] = '{"divu 100/7", 4'd4, 32'd100,       32'd7,         32'd2,         32'd14,        10, 1'b0};
      vecs[6] = '{"div 7/-2",   4'd3, 32'd7,         32'hFFFF_FFFE, 32'd1,         32'hFFFF_FFFD, 10, 1'b0};
      vecs[7] = '{"div -5/0",   4'd3, 32'hFFFF_FFFB, 32'd0,         32'hFFFF_FFFB, 32'hFFFF_FFFF, 10, 1'b0};
      vecs[8] = '{"mult 7*-1",  4'd1, 32'd7,         32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFF9, 5,  1'b0};
      vecs[9] = '{"multu 2^32", 4'd2, 32'h0001_0000, 32'h0001_0000, 32'd1,         32'd0,         5,  1'b0};

      // Reset state
      #12;
      chk("reset busy", 64'(busy), 64'd0);
      chk("reset HI:LO", {HI, LO}, 64'd0);
      @(negedge clk);
      reset = 1'b1;

      foreach (vecs[i])
         run_op(vecs[i].name, vecs[i].op, vecs[i].a, vecs[i].b,
                vecs[i].hi, vecs[i].lo, vecs[i].cyc, vecs[i].poke);

      // MTLO while idle: LO written at the issue edge, busy stays low
      run_op("mtlo", 4'd6, 32'hABCD, 32'd0, mhi, 32'hABCD, 0, 1'b0);
      chk("mtlo busy", 64'(busy), 64'd0);
      // Undefined op: no effect
      run_op("undef op", 4'd15, 32'h5555, 32'h6666, mhi, mlo, 0, 1'b0);

      // Accumulate from HI:LO = 0:1
      run_op("mthi 0", 4'd5, 32'd0, 32'd0, 32'd0, mlo, 0, 1'b0);
      run_op("mtlo 1", 4'd6, 32'd1, 32'd0, 32'd0, 32'd1, 0, 1'b0);
`ifdef MDU_MADD_EN
      run_op("madd", 4'd7, 32'd2, 32'd3, 32'd0, 32'd7, 5, 1'b0);
      run_op("msub", 4'd9, 32'd4, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5, 1'b0);
      run_op("maddu", 4'd8, 32'hFFFF_FFFF, 32'd2, 32'd1, 32'hFFFF_FFFD, 5, 1'b0);
`else
      run_op("madd off", 4'd7, 32'd2, 32'd3, 32'd0, 32'd1, 0, 1'b0);
      run_op("msub off", 4'd9, 32'd2, 32'd3, 32'd0, 32'd1, 0, 1'b0);
`endif

      // Load distinct nonzero values, then reset in the middle of a DIV
      run_op("mthi pre", 4'd5, 32'h0BAD, 32'd0, 32'h0BAD, mlo, 0, 1'b0);
      @(negedge clk);
      start = 1'b1; op_i = 4'd3; a_i = 32'd100; b_i = 32'd7;
      @(negedge clk);
      start = 1'b0; op_i = 4'd0;
      chk("pre-reset busy", 64'(busy), 64'd1);
      repeat (3) @(posedge clk);
      #2 reset = 1'b0;
      #1;
      chk("async reset busy", 64'(busy), 64'd0);
      chk("async reset HI:LO", {HI, LO}, 64'd0);
      @(negedge clk);
      reset = 1'b1;
      repeat (15) @(negedge clk);
      chk("post-reset busy", 64'(busy), 64'd0);
      chk("post-reset HI:LO", {HI, LO}, 64'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
